fifo_uart_tx: RTL

//   Read-side consumer for the on-chip FIFO: pops elements via the FIFO's empty/read

---
 rtl/fifo_uart_tx.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a FIFO through its empty/read handshake and sends
// each element as start + LSB-first data + stop, back-to-back when data is waiting.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_enable,
    input  logic                 i_fifo_empty,
    input  logic [DATA_BITS-1:0] i_fifo_data,
    output logic                 o_fifo_read,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_frame_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic                   tx_reg, tx_next;
    logic                   busy_reg, busy_next;

    logic bit_end;
    logic frame_end;
    logic pop;

    assign bit_end   = (cnt_reg == CNT_LAST);
    // Final cycle of the final stop bit: the only mid-frame point where a pop may occur.
    assign frame_end = (state_reg == STOP) && bit_end && (idx_reg == STOP_LAST);
    assign pop       = !i_rst && i_enable && !i_fifo_empty &&
                       ((state_reg == IDLE) || frame_end);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
            busy_reg  <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        shift_next = shift_reg;
        tx_next    = tx_reg;
        busy_next  = busy_reg;

        case (state_reg)
            IDLE: begin
                cnt_next  = '0;
                idx_next  = '0;
                tx_next   = 1'b1;
                busy_next = 1'b0;
            end
            START: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (bit_end) begin
                    cnt_next   = '0;
                    state_next = DATA;
                    tx_next    = shift_reg[0];
                end
            end
            DATA: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (bit_end) begin
                    cnt_next = '0;
                    if (idx_reg == DATA_LAST) begin
                        idx_next   = '0;
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        idx_next   = idx_reg + IDX_W'(1);
                        shift_next = shift_reg >> 1;
                        tx_next    = shift_next[0];
                    end
                end
            end
            STOP: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (bit_end) begin
                    cnt_next = '0;
                    if (idx_reg == STOP_LAST) begin
                        idx_next   = '0;
                        state_next = IDLE;
                        tx_next    = 1'b1;
                        busy_next  = 1'b0;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A pop overrides the frame-end return to IDLE so the next start bit follows at once.
        if (pop) begin
            state_next = START;
            cnt_next   = '0;
            idx_next   = '0;
            shift_next = i_fifo_data;
            tx_next    = 1'b0;
            busy_next  = 1'b1;
        end
    end

    assign o_fifo_read  = pop;
    assign o_tx         = tx_reg;
    assign o_busy       = busy_reg;
    assign o_frame_done = frame_end && !i_rst;

endmodule
